// File: rtl/enabler_scheduler_pkg.sv
// Shared definitions for the clock-enabler scheduler.
//   - Default requester count and burst-length width.
//   - FSM state encoding shared by the top and any future siblings.
package enabler_scheduler_pkg;

    localparam int unsigned DefNreq = 4;
    localparam int unsigned DefLenw = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/enabler_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i     - request vector, bit i = requester i
//   pointer_i - highest-priority requester; the search runs upward with wrap
//   winner_o  - one-hot winner, all zero when no request is pending
//   index_o   - binary index of the winner (0 when no request is pending)
module enabler_scheduler_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] pointer_i,
    output logic [NREQ-1:0] winner_o,
    output logic [IDXW-1:0] index_o
);

    always_comb begin
        logic              found;
        int unsigned       cand;
        logic [IDXW-1:0]   cand_idx;
        winner_o = '0;
        index_o  = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand     = (int'(pointer_i) + i) % NREQ;
            cand_idx = IDXW'(cand);
            if (!found && req_i[cand_idx]) begin
                found              = 1'b1;
                winner_o[cand_idx] = 1'b1;
                index_o            = cand_idx;
            end
        end
    end

endmodule

// File: rtl/enabler_scheduler.sv
// Scheduler for the shared clock enabler (eclk = clk & enb).
// Grants bursts of gated clock pulses to NREQ requesters in round-robin order.
// Ports:
//   clk       - system clock, also the enabler clock
//   reset     - asynchronous active-high reset
//   req       - request levels, bit i = requester i
//   len       - packed burst lengths, requester i at [i*LENW +: LENW]
//   gnt       - one-hot grant, held from ARM through DONE
//   enb       - enabler enable, launched on the falling edge of clk
//   busy      - high whenever the FSM is not idle
//   done      - one-cycle pulse at burst completion
//   remaining - pulses still to be issued in the current burst
module enabler_scheduler
    import enabler_scheduler_pkg::*;
#(
    parameter int unsigned NREQ = DefNreq,
    parameter int unsigned LENW = DefLenw,
    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] len,
    output logic [NREQ-1:0]      gnt,
    output logic                 enb,
    output logic                 busy,
    output logic                 done,
    output logic [LENW-1:0]      remaining
);

    state_e            state_q, state_d;
    logic [LENW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic              enb_q;
    logic              enb_next;

    logic [NREQ-1:0]   win_oh;
    logic [IDXW-1:0]   win_idx;
    logic [LENW-1:0]   lens [NREQ];

    enabler_scheduler_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i     (req),
        .pointer_i (ptr_q),
        .winner_o  (win_oh),
        .index_o   (win_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            lens[i] = len[i*LENW +: LENW];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d   = win_oh;
                    owner_d = win_idx;
                    cnt_d   = lens[win_idx];
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                state_d = (cnt_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                // RUN is only entered with a non-zero count, so this never wraps.
                cnt_d = cnt_q - LENW'(1);
                if (cnt_q == LENW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Owner drops to lowest priority for the next decision.
                ptr_d   = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Launching enb on the falling edge keeps it stable while clk is high,
    // so the AND-gated eclk cannot glitch.
    assign enb_next = (state_q == S_RUN);

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            enb_q <= 1'b0;
        end else begin
            enb_q <= enb_next;
        end
    end

    assign gnt       = gnt_q;
    assign enb       = enb_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign remaining = cnt_q;

endmodule

// File: tb/tb_enabler_scheduler.sv
// Directed self-checking bench for enabler_scheduler (NREQ=4, LENW=4).
// eclk is formed locally as clk & enb, mirroring the external enabler cell.
module tb_enabler_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  gnt;
    logic        enb;
    logic        busy;
    logic        done;
    logic [3:0]  remaining;
    logic        eclk;

    int total;
    int bad;
    int pulses;
    int enb_rises;
    int done_cnt;
    int enb_glitch;

    enabler_scheduler #(
        .NREQ (4),
        .LENW (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .len       (len),
        .gnt       (gnt),
        .enb       (enb),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    assign eclk = clk & enb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge eclk) pulses++;
    always @(posedge enb) enb_rises++;
    always @(posedge done) done_cnt++;
    // enb may only move while clk is low, except for the asynchronous reset drop.
    always @(enb) if (clk === 1'b1 && reset === 1'b0) enb_glitch++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input logic [3:0] v);
        len[i*4 +: 4] = v;
    endtask

    // Called while IDLE with req/len already driven; the first tick is the grant decision.
    // req is cleared once drop_at pulses have been seen; scramble rewrites len mid-burst.
    task automatic run_burst(input string name, input logic [3:0] eg, input int l,
                             input int drop_at, input bit scramble);
        int base_p;
        int base_e;
        int base_d;
        int t;
        bit got;
        base_p = pulses;
        base_e = enb_rises;
        base_d = done_cnt;
        got    = 1'b0;
        t      = 0;
        tick();
        check({name, " gnt"}, 32'(gnt), 32'(eg));
        check({name, " busy"}, 32'(busy), 32'd1);
        check({name, " rem_arm"}, 32'(remaining), 32'(l));
        for (int i = 1; i <= 40 && !got; i++) begin
            if (pulses - base_p >= drop_at) req = 4'b0000;
            if (scramble && i == 2) len = ~len;
            tick();
            t = i;
            if (done === 1'b1) begin
                got = 1'b1;
                check({name, " rem_done"}, 32'(remaining), 32'd0);
            end else begin
                check({name, " rem"}, 32'(remaining), 32'(l - (i - 1)));
            end
        end
        check({name, " done_seen"}, 32'(got), 32'd1);
        check({name, " latency"}, 32'(t), (l == 0) ? 32'd1 : 32'(l + 1));
        check({name, " pulses"}, 32'(pulses - base_p), 32'(l));
        check({name, " gnt_in_done"}, 32'(gnt), 32'(eg));
        tick();
        check({name, " done_1cyc"}, 32'(done), 32'd0);
        check({name, " idle_busy"}, 32'(busy), 32'd0);
        check({name, " idle_gnt"}, 32'(gnt), 32'd0);
        check({name, " idle_enb"}, 32'(enb), 32'd0);
        check({name, " idle_rem"}, 32'(remaining), 32'd0);
        check({name, " pulses_after"}, 32'(pulses - base_p), 32'(l));
        check({name, " enb_rises"}, 32'(enb_rises - base_e), (l > 0) ? 32'd1 : 32'd0);
        check({name, " done_pulses"}, 32'(done_cnt - base_d), 32'd1);
    endtask

    logic [3:0] rr_exp [6];

    initial begin
        int base_p;
        int base_d;
        bit hit;
        total      = 0;
        bad        = 0;
        pulses     = 0;
        enb_rises  = 0;
        done_cnt   = 0;
        enb_glitch = 0;
        reset      = 1'b1;
        req        = 4'b1111;
        len        = 16'h1112;

        // Reset holds everything quiet even with all requests pending.
        tick();
        tick();
        check("rst gnt", 32'(gnt), 32'd0);
        check("rst enb", 32'(enb), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst rem", 32'(remaining), 32'd0);
        reset = 1'b0;
        run_burst("first", 4'b0001, 2, 0, 1'b0);

        // Single burst for requester 2, len change after latching is ignored.
        req = 4'b0100;
        set_len(2, 4'd3);
        run_burst("single", 4'b0100, 3, 0, 1'b1);

        // Round-robin with requests held; reset first so the pointer is 0.
        reset = 1'b1;
        #2;
        len   = 16'h1111;
        req   = 4'b1011;
        reset = 1'b0;
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b1000;
        rr_exp[3] = 4'b0001;
        rr_exp[4] = 4'b0010;
        rr_exp[5] = 4'b1000;
        for (int k = 0; k < 6; k++) begin
            run_burst($sformatf("rr%0d", k), rr_exp[k], 1, 99, 1'b0);
        end
        req = 4'b0000;

        // Zero and maximum lengths on requester 0 (pointer is 0 after owner 3).
        set_len(0, 4'd0);
        req = 4'b0001;
        run_burst("zero", 4'b0001, 0, 0, 1'b0);
        set_len(0, 4'd15);
        req = 4'b0001;
        run_burst("max", 4'b0001, 15, 0, 1'b0);

        // Owner 1 drops its request after 2 of 5 pulses.
        set_len(1, 4'd5);
        req = 4'b0010;
        run_burst("drop", 4'b0010, 5, 2, 1'b0);

        // Reset on the third pulse of requester 2's burst.
        set_len(2, 4'd6);
        req    = 4'b0100;
        base_p = pulses;
        base_d = done_cnt;
        hit    = 1'b0;
        tick();
        req = 4'b0000;
        check("mrst gnt", 32'(gnt), 32'b0100);
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (pulses - base_p == 3) hit = 1'b1;
        end
        check("mrst reach3", 32'(hit), 32'd1);
        check("mrst enb_pre", 32'(enb), 32'd1);
        reset = 1'b1;
        #1;
        check("mrst enb", 32'(enb), 32'd0);
        check("mrst gnt0", 32'(gnt), 32'd0);
        check("mrst busy", 32'(busy), 32'd0);
        check("mrst rem", 32'(remaining), 32'd0);
        tick();
        tick();
        check("mrst pulses", 32'(pulses - base_p), 32'd3);
        check("mrst no_done", 32'(done_cnt - base_d), 32'd0);
        // Pointer back at 0: requester 0 wins with everyone asking.
        len   = 16'h1111;
        req   = 4'b1111;
        reset = 1'b0;
        run_burst("ptr0", 4'b0001, 1, 0, 1'b0);

        // Move pointer to 2, then requesters 1 and 2 rise together.
        req = 4'b0010;
        run_burst("ptr2", 4'b0010, 1, 0, 1'b0);
        set_len(1, 4'd2);
        set_len(2, 4'd1);
        req = 4'b0110;
        run_burst("sim_a", 4'b0100, 1, 99, 1'b0);
        run_burst("sim_b", 4'b0010, 2, 0, 1'b0);

        check("enb_glitch", 32'(enb_glitch), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
